ram_port_arbiter: RTL and testbench

Cycle-by-cycle arbiter sharing the single-port on-chip RAM between three requesters: the power-on program loader, the SLC-3 CPU memory interface, and a low-priority debug/peek port driven from the switches and HEX display. It replaces the static `we_select` muxing in the top level. It adds a load-phase lock, fixed priority with a starvation guard for the debug port, a read-valid pipeline matched to the RAM's 1-cycle registered read, and out-of-range address trapping.

---
 rtl/ram_port_arbiter_if.sv | 51 +++++
 rtl/ram_port_arbiter.sv | 119 +++++++++++
 tb/tb_ram_port_arbiter.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/ram_port_arbiter_if.sv
// rtl/ram_port_arbiter_if.sv - requester and RAM-side signal bundle for ram_port_arbiter
interface ram_port_arbiter_if #(
  parameter int ADDR_W = 10
);
  // requester side
  logic              ld_req;
  logic              cpu_req;
  logic              dbg_req;
  logic              ld_we;
  logic              cpu_we;
  logic              dbg_we;
  logic [15:0]       ld_addr;
  logic [15:0]       cpu_addr;
  logic [15:0]       dbg_addr;
  logic [15:0]       ld_wdata;
  logic [15:0]       cpu_wdata;
  logic [15:0]       dbg_wdata;
  logic              ld_done;
  logic              ld_gnt;
  logic              cpu_gnt;
  logic              dbg_gnt;
  logic              ld_rvalid;
  logic              cpu_rvalid;
  logic              dbg_rvalid;
  logic [15:0]       rdata;
  // RAM side
  logic [ADDR_W-1:0] ram_addr;
  logic [15:0]       ram_data;
  logic              ram_rden;
  logic              ram_wren;
  logic [15:0]       ram_q;
  // status
  logic              loading;
  logic              addr_err;

  modport master (
    output ld_req, cpu_req, dbg_req, ld_we, cpu_we, dbg_we,
    output ld_addr, cpu_addr, dbg_addr, ld_wdata, cpu_wdata, dbg_wdata,
    output ld_done, ram_q,
    input  ld_gnt, cpu_gnt, dbg_gnt, ld_rvalid, cpu_rvalid, dbg_rvalid, rdata,
    input  ram_addr, ram_data, ram_rden, ram_wren, loading, addr_err
  );

  modport slave (
    input  ld_req, cpu_req, dbg_req, ld_we, cpu_we, dbg_we,
    input  ld_addr, cpu_addr, dbg_addr, ld_wdata, cpu_wdata, dbg_wdata,
    input  ld_done, ram_q,
    output ld_gnt, cpu_gnt, dbg_gnt, ld_rvalid, cpu_rvalid, dbg_rvalid, rdata,
    output ram_addr, ram_data, ram_rden, ram_wren, loading, addr_err
  );
endinterface

// File: rtl/ram_port_arbiter.sv
// rtl/ram_port_arbiter.sv - shares single-port RAM between loader, CPU and debug port
module ram_port_arbiter #(
  parameter int ADDR_W       = 10,
  parameter int STARVE_LIMIT = 8
) (
  input logic               Clk,
  input logic               Reset_al,
  ram_port_arbiter_if.slave bus
);
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  typedef enum logic {
    LOAD = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] starve_cnt;
  logic             oor_rd_q;
  logic             starved;
  logic             any_gnt;
  logic             win_we;
  logic             oor;
  logic [15:0]      win_addr;
  logic [15:0]      win_wdata;

  assign starved = (starve_cnt == CNT_W'(STARVE_LIMIT));

  // An out-of-range read returns zero instead of whatever the RAM last latched.
  assign bus.rdata = oor_rd_q ? 16'h0000 : bus.ram_q;

  // Grant selection: loader always wins; debug jumps the CPU only once starved.
  always_comb begin
    bus.ld_gnt  = bus.ld_req;
    bus.cpu_gnt = 1'b0;
    bus.dbg_gnt = 1'b0;
    if (state == RUN && !bus.ld_req) begin
      if (bus.dbg_req && starved) begin
        bus.dbg_gnt = 1'b1;
      end else if (bus.cpu_req) begin
        bus.cpu_gnt = 1'b1;
      end else if (bus.dbg_req) begin
        bus.dbg_gnt = 1'b1;
      end
    end
  end

  // Route the winner onto the RAM port; out-of-range accesses are granted but never reach the RAM.
  always_comb begin
    any_gnt   = 1'b1;
    win_we    = 1'b0;
    win_addr  = 16'h0000;
    win_wdata = 16'h0000;
    if (bus.ld_gnt) begin
      win_we    = bus.ld_we;
      win_addr  = bus.ld_addr;
      win_wdata = bus.ld_wdata;
    end else if (bus.cpu_gnt) begin
      win_we    = bus.cpu_we;
      win_addr  = bus.cpu_addr;
      win_wdata = bus.cpu_wdata;
    end else if (bus.dbg_gnt) begin
      win_we    = bus.dbg_we;
      win_addr  = bus.dbg_addr;
      win_wdata = bus.dbg_wdata;
    end else begin
      any_gnt = 1'b0;
    end
    oor          = any_gnt && ((win_addr >> ADDR_W) != 16'h0000);
    bus.ram_addr = win_addr[ADDR_W-1:0];
    bus.ram_data = win_wdata;
    bus.ram_wren = any_gnt && win_we && !oor;
    bus.ram_rden = any_gnt && !win_we && !oor;
  end

  // Phase FSM plus all registered outputs: starvation count, read-valid pipe, error flag.
  always_ff @(posedge Clk) begin
    if (!Reset_al) begin
      state          <= LOAD;
      bus.loading    <= 1'b1;
      starve_cnt     <= '0;
      bus.ld_rvalid  <= 1'b0;
      bus.cpu_rvalid <= 1'b0;
      bus.dbg_rvalid <= 1'b0;
      oor_rd_q       <= 1'b0;
      bus.addr_err   <= 1'b0;
    end else begin
      case (state)
        LOAD: begin
          if (bus.ld_done) begin
            state       <= RUN;
            bus.loading <= 1'b0;
          end
        end
        default: begin
          state       <= RUN;
          bus.loading <= 1'b0;
        end
      endcase

      if (state == RUN && bus.dbg_req && !bus.dbg_gnt) begin
        if (!starved) begin
          starve_cnt <= starve_cnt + CNT_W'(1);
        end
      end else begin
        starve_cnt <= '0;
      end

      bus.ld_rvalid  <= bus.ld_gnt && !bus.ld_we;
      bus.cpu_rvalid <= bus.cpu_gnt && !bus.cpu_we;
      bus.dbg_rvalid <= bus.dbg_gnt && !bus.dbg_we;
      oor_rd_q       <= oor && !win_we;

      if (oor) begin
        bus.addr_err <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb/tb_ram_port_arbiter.sv - directed self-checking bench for ram_port_arbiter
module tb_ram_port_arbiter;
  logic Clk;
  logic Reset_al;
  int   n_cmp;
  int   n_err;

  logic [15:0] mem [0:1023];

  ram_port_arbiter_if #(.ADDR_W(10)) bus ();

  ram_port_arbiter #(
    .ADDR_W      (10),
    .STARVE_LIMIT(8)
  ) dut (
    .Clk     (Clk),
    .Reset_al(Reset_al),
    .bus     (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // single-port RAM with 1-cycle registered read
  always @(posedge Clk) begin
    if (bus.ram_wren) mem[bus.ram_addr] <= bus.ram_data;
    if (bus.ram_rden) bus.ram_q <= mem[bus.ram_addr];
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle_reqs();
    bus.ld_req  = 1'b0;
    bus.cpu_req = 1'b0;
    bus.dbg_req = 1'b0;
    bus.ld_done = 1'b0;
  endtask

  task automatic cpu_set(input logic req, input logic we, input logic [15:0] addr, input logic [15:0] wdata);
    bus.cpu_req   = req;
    bus.cpu_we    = we;
    bus.cpu_addr  = addr;
    bus.cpu_wdata = wdata;
  endtask

  // move to the next negedge, then let combinational outputs settle
  task automatic step();
    @(negedge Clk);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    Reset_al = 1'b0;
    idle_reqs();
    bus.ld_we = 1'b0;  bus.ld_addr = 16'h0;  bus.ld_wdata = 16'h0;
    bus.dbg_we = 1'b0; bus.dbg_addr = 16'h0; bus.dbg_wdata = 16'h0;
    cpu_set(1'b0, 1'b0, 16'h0, 16'h0);
    repeat (2) @(posedge Clk);

    // reset state
    step();
    Reset_al = 1'b1;
    #1;
    check("rst_loading", {15'b0, bus.loading}, 16'h1);
    check("rst_addr_err", {15'b0, bus.addr_err}, 16'h0);
    check("rst_rvalid", {13'b0, bus.ld_rvalid, bus.cpu_rvalid, bus.dbg_rvalid}, 16'h0);
    check("rst_idle_ram", {14'b0, bus.ram_wren, bus.ram_rden}, 16'h0);

    // LOAD: loader write wins, CPU locked out
    step();
    bus.ld_req = 1'b1; bus.ld_we = 1'b1; bus.ld_addr = 16'h0005; bus.ld_wdata = 16'h1234;
    cpu_set(1'b1, 1'b0, 16'h0005, 16'h0);
    #1;
    check("load_gnts", {13'b0, bus.ld_gnt, bus.cpu_gnt, bus.dbg_gnt}, 16'h4);
    check("load_wren", {14'b0, bus.ram_wren, bus.ram_rden}, 16'h2);
    check("load_addr", {6'b0, bus.ram_addr}, 16'h0005);
    check("load_data", bus.ram_data, 16'h1234);

    step();
    bus.ld_req = 1'b0;
    bus.ld_done = 1'b1;
    #1;
    check("load_cpu_denied", {15'b0, bus.cpu_gnt}, 16'h0);
    check("load_loading", {15'b0, bus.loading}, 16'h1);
    check("load_wr_no_rvalid", {15'b0, bus.ld_rvalid}, 16'h0);

    // RUN: CPU read of loaded word
    step();
    bus.ld_done = 1'b0;
    #1;
    check("run_loading", {15'b0, bus.loading}, 16'h0);
    check("run_cpu_gnt", {13'b0, bus.ld_gnt, bus.cpu_gnt, bus.dbg_gnt}, 16'h2);
    check("run_cpu_rden", {14'b0, bus.ram_wren, bus.ram_rden}, 16'h1);

    step();
    cpu_set(1'b0, 1'b0, 16'h0, 16'h0);
    #1;
    check("rd5_rvalid", {15'b0, bus.cpu_rvalid}, 16'h1);
    check("rd5_rdata", bus.rdata, 16'h1234);

    step();
    #1;
    check("rd5_rvalid_1cyc", {15'b0, bus.cpu_rvalid}, 16'h0);

    // starvation guard: 8 CPU grants then one debug grant, repeating
    step();
    cpu_set(1'b1, 1'b0, 16'h0005, 16'h0);
    bus.dbg_req = 1'b1; bus.dbg_we = 1'b0; bus.dbg_addr = 16'h0006;
    #1;
    for (int i = 1; i <= 19; i++) begin
      check($sformatf("starve_c%0d", i), {14'b0, bus.cpu_gnt, bus.dbg_gnt},
            (i % 9 == 0) ? 16'h1 : 16'h2);
      step();
      #1;
    end
    bus.dbg_req = 1'b0;
    cpu_set(1'b0, 1'b0, 16'h0, 16'h0);

    // loader beats CPU in RUN, CPU follows next cycle
    step();
    bus.ld_req = 1'b1; bus.ld_we = 1'b0; bus.ld_addr = 16'h0007;
    cpu_set(1'b1, 1'b0, 16'h0005, 16'h0);
    #1;
    check("prio_ld", {13'b0, bus.ld_gnt, bus.cpu_gnt, bus.dbg_gnt}, 16'h4);
    step();
    bus.ld_req = 1'b0;
    #1;
    check("prio_cpu_next", {13'b0, bus.ld_gnt, bus.cpu_gnt, bus.dbg_gnt}, 16'h2);
    check("prio_ld_rvalid", {15'b0, bus.ld_rvalid}, 16'h1);

    // out-of-range CPU read
    step();
    cpu_set(1'b1, 1'b0, 16'h0400, 16'h0);
    #1;
    check("oor_gnt", {15'b0, bus.cpu_gnt}, 16'h1);
    check("oor_ram_off", {14'b0, bus.ram_wren, bus.ram_rden}, 16'h0);
    step();
    cpu_set(1'b0, 1'b0, 16'h0, 16'h0);
    #1;
    check("oor_rvalid", {15'b0, bus.cpu_rvalid}, 16'h1);
    check("oor_rdata", bus.rdata, 16'h0000);
    check("oor_addr_err", {15'b0, bus.addr_err}, 16'h1);

    // write then read-after-write at the top address
    step();
    cpu_set(1'b1, 1'b1, 16'h03FF, 16'hBEEF);
    #1;
    check("wr_ram_en", {14'b0, bus.ram_wren, bus.ram_rden}, 16'h2);
    check("wr_ram_addr", {6'b0, bus.ram_addr}, 16'h03FF);
    step();
    cpu_set(1'b1, 1'b0, 16'h03FF, 16'h0);
    #1;
    check("wr_no_rvalid", {15'b0, bus.cpu_rvalid}, 16'h0);
    check("raw_gnt", {15'b0, bus.cpu_gnt}, 16'h1);
    step();
    cpu_set(1'b0, 1'b0, 16'h0, 16'h0);
    #1;
    check("raw_rvalid", {15'b0, bus.cpu_rvalid}, 16'h1);
    check("raw_rdata", bus.rdata, 16'hBEEF);
    check("addr_err_sticky", {15'b0, bus.addr_err}, 16'h1);

    // reset while a read is in flight
    step();
    cpu_set(1'b1, 1'b0, 16'h0005, 16'h0);
    Reset_al = 1'b0;
    #1;
    check("inflight_gnt", {15'b0, bus.cpu_gnt}, 16'h1);
    step();
    Reset_al = 1'b1;
    #1;
    check("inflight_rvalid", {15'b0, bus.cpu_rvalid}, 16'h0);
    check("inflight_loading", {15'b0, bus.loading}, 16'h1);
    check("inflight_addr_err", {15'b0, bus.addr_err}, 16'h0);
    check("inflight_cpu_locked", {15'b0, bus.cpu_gnt}, 16'h0);
    cpu_set(1'b0, 1'b0, 16'h0, 16'h0);

    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
